// File: rtl/universal_shift_register_pkg.sv
// rtl/universal_shift_register_pkg.sv - mode encodings shared by the shift register and its bench
package universal_shift_register_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/mux_4_1.sv
// rtl/mux_4_1.sv - 1-bit 4-input multiplexer, one per shift register bit
module mux_4_1 (
  input  logic [1:0] sel,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  output logic       y
);

  always_comb begin
    y = d0;
    case (sel)
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - hold/shift-right/shift-left/load register
// with a count of loaded bits still inside and a done pulse when it drains.
module universal_shift_register
  import universal_shift_register_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] p_in,
  output logic             sout_r,
  output logic             sout_l,
  output logic [WIDTH-1:0] status,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             done
);

  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q, done_d;

  // Mux inputs follow the mode encoding: d0 hold, d1 right, d2 left, d3 load.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic right_src;
    logic left_src;

    if (i == WIDTH - 1) begin : g_right_edge
      assign right_src = sin;
    end else begin : g_right_inner
      assign right_src = q_q[i+1];
    end

    if (i == 0) begin : g_left_edge
      assign left_src = sin;
    end else begin : g_left_inner
      assign left_src = q_q[i-1];
    end

    mux_4_1 u_mux (
      .sel (mode),
      .d0  (q_q[i]),
      .d1  (right_src),
      .d2  (left_src),
      .d3  (p_in[i]),
      .y   (q_d[i])
    );
  end

  // Count saturates at zero so an empty register can keep shifting freely.
  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    case (mode)
      MODE_LOAD: count_d = CNT_FULL;
      MODE_SHR, MODE_SHL: begin
        if (count_q != '0) begin
          count_d = count_q - CNT_ONE;
        end
        done_d = (count_q == CNT_ONE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q     <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign status = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];
  assign count  = count_q;
  assign empty  = (count_q == '0);
  assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - scoreboard bench for the shift register
module tb_universal_shift_register;
  import universal_shift_register_pkg::*;

  typedef struct {
    int status;
    int count;
    int done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       sin;
  logic [7:0] p_in;
  logic       sout_r, sout_l, empty, done;
  logic [7:0] status;
  logic [3:0] count;

  logic       rst5;
  logic [1:0] mode5;
  logic       sin5;
  logic [4:0] p_in5;
  logic       sout_r5, sout_l5, empty5, done5;
  logic [4:0] status5;
  logic [2:0] count5;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t sb[$];
  int   m_q, m_cnt, m_done;

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .sin(sin), .p_in(p_in),
    .sout_r(sout_r), .sout_l(sout_l), .status(status), .count(count),
    .empty(empty), .done(done)
  );

  universal_shift_register #(.WIDTH(5)) u_dut5 (
    .clk(clk), .rst(rst5), .mode(mode5), .sin(sin5), .p_in(p_in5),
    .sout_r(sout_r5), .sout_l(sout_l5), .status(status5), .count(count5),
    .empty(empty5), .done(done5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one operation before the edge, record what the register must hold
  // after it, and return just after that edge.
  task automatic do_op(input logic [1:0] m, input logic s, input logic [7:0] p);
    exp_t e;
    @(negedge clk);
    mode = m;
    sin  = s;
    p_in = p;
    m_done = 0;
    case (m)
      MODE_LOAD: begin
        m_q   = int'(p);
        m_cnt = 8;
      end
      MODE_SHR, MODE_SHL: begin
        if (m == MODE_SHR) m_q = (m_q >> 1) | (int'(s) << 7);
        else               m_q = ((m_q << 1) | int'(s)) & 8'hFF;
        m_done = (m_cnt == 1) ? 1 : 0;
        m_cnt  = (m_cnt > 0) ? m_cnt - 1 : 0;
      end
      default: ;
    endcase
    e.status = m_q;
    e.count  = m_cnt;
    e.done   = m_done;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    #2;
    rst  = 1'b1;
    mode = MODE_HOLD;
    #1;
    chk("arst_status", status, 0);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_done", done, 0);
    m_q = 0; m_cnt = 0; m_done = 0;
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("status", status, e.status);
        chk("count", count, e.count);
        chk("done", done, e.done);
        chk("empty", empty, (e.count == 0) ? 1 : 0);
        chk("sout_r", sout_r, e.status & 1);
        chk("sout_l", sout_l, (e.status >> 7) & 1);
      end
    end
  end

  initial begin : stim
    int e5;
    rst = 1'b1; mode = MODE_HOLD; sin = 1'b0; p_in = '0;
    rst5 = 1'b1; mode5 = MODE_HOLD; sin5 = 1'b0; p_in5 = '0;
    m_q = 0; m_cnt = 0; m_done = 0;
    #2;
    chk("rst_status", status, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_done", done, 0);
    chk("rst_sout_r", sout_r, 0);
    chk("rst_sout_l", sout_l, 0);
    #1;
    rst = 1'b0;

    // Parallel to serial, LSB first.
    do_op(MODE_LOAD, 1'b0, 8'hA5);
    chk("a5_lsb", sout_r, 1);
    chk("a5_count", count, 8);
    for (int i = 0; i < 8; i++) begin
      do_op(MODE_SHR, 1'b0, 8'h00);
      chk("a5_done_n", done, (i == 7) ? 1 : 0);
    end
    chk("a5_status", status, 0);
    do_op(MODE_HOLD, 1'b0, 8'h00);
    chk("a5_done_1cyc", done, 0);

    do_op(MODE_LOAD, 1'b0, 8'h81);
    do_op(MODE_SHL, 1'b1, 8'h00);
    chk("shl_1", status, 8'h03);
    do_op(MODE_SHL, 1'b1, 8'h00);
    chk("shl_2", status, 8'h07);
    do_op(MODE_SHL, 1'b1, 8'h00);
    chk("shl_3", status, 8'h0F);
    chk("shl_sout_l", sout_l, 0);
    chk("shl_count", count, 5);
    chk("shl_empty", empty, 0);

    // Reload mid-word discards the remainder without a done pulse.
    do_op(MODE_LOAD, 1'b0, 8'hFF);
    for (int i = 0; i < 3; i++) do_op(MODE_SHR, 1'b0, 8'h00);
    do_op(MODE_LOAD, 1'b0, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      do_op(MODE_HOLD, 1'b0, 8'h00);
      chk("reload_done", done, 0);
    end
    chk("reload_count", count, 8);
    chk("reload_status", status, 8'h3C);

    async_reset();
    do_op(MODE_SHR, 1'b1, 8'h00);
    chk("free_1", status, 8'h80);
    do_op(MODE_SHR, 1'b1, 8'h00);
    chk("free_2", status, 8'hC0);
    chk("free_count", count, 0);
    chk("free_done", done, 0);

    do_op(MODE_LOAD, 1'b0, 8'h5A);
    do_op(MODE_SHR, 1'b0, 8'h00);
    do_op(MODE_SHR, 1'b0, 8'h00);
    async_reset();

    for (int i = 0; i < 400; i++) begin
      do_op(2'($urandom_range(0, 3)), 1'($urandom), 8'($urandom));
    end
    do_op(MODE_HOLD, 1'b0, 8'h00);
    #5;
    chk("sb_drained", sb.size(), 0);

    // Narrow instance: load then drain leftwards.
    @(negedge clk);
    rst5 = 1'b0;
    mode5 = MODE_LOAD; p_in5 = 5'b10011; sin5 = 1'b0;
    @(posedge clk); #1;
    chk("w5_load", status5, 5'b10011);
    chk("w5_load_count", count5, 5);
    e5 = 5'b10011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mode5 = MODE_SHL;
      @(posedge clk); #1;
      e5 = (e5 << 1) & 5'h1F;
      chk("w5_status", status5, e5);
      chk("w5_count", count5, 4 - i);
      chk("w5_done", done5, (i == 4) ? 1 : 0);
    end
    chk("w5_empty", empty5, 1);
    @(negedge clk);
    mode5 = MODE_HOLD;
    @(posedge clk); #1;
    chk("w5_done_1cyc", done5, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
